// File: rtl/id_pkg.sv
// Shared defaults for the decode-stage operand resolution slice.
// Register 0 is architecturally hard-wired to zero.
package id_pkg;

    localparam int NREG_DFLT = 32;
    localparam int AW_DFLT   = 5;
    localparam int DW_DFLT   = 32;
    localparam int NRD_DFLT  = 2;
    localparam int NFWD_DFLT = 3;
    localparam int CW_DFLT   = 2;

    localparam int REG_ZERO  = 0;

endpackage

// File: rtl/id_fwd_scoreboard_if.sv
// Decode-stage bus: ID instruction, register file data, forwarding stages,
// write-back retirement and the resolved operand / stall results.
interface id_fwd_scoreboard_if
    import id_pkg::*;
#(
    parameter int AW   = AW_DFLT,
    parameter int DW   = DW_DFLT,
    parameter int NRD  = NRD_DFLT,
    parameter int NFWD = NFWD_DFLT
) ();

    logic                 id_valid;
    logic                 id_fire;
    logic                 id_we;
    logic [AW-1:0]        id_waddr;
    logic [NRD-1:0]       id_rd_en;
    logic [NRD*AW-1:0]    id_raddr;
    logic [NRD*DW-1:0]    rf_rdata;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD*AW-1:0]   fwd_waddr;
    logic [NFWD-1:0]      fwd_rdy;
    logic [NFWD*DW-1:0]   fwd_wdata;
    logic                 wb_commit;
    logic [AW-1:0]        wb_waddr;
    logic                 flush;
    logic [NRD*DW-1:0]    opnd;
    logic                 stall;
    logic                 sb_full;
    logic [31:0]          stall_cnt;

    modport master (
        output id_valid, id_fire, id_we, id_waddr, id_rd_en, id_raddr, rf_rdata,
        output fwd_valid, fwd_we, fwd_waddr, fwd_rdy, fwd_wdata,
        output wb_commit, wb_waddr, flush,
        input  opnd, stall, sb_full, stall_cnt
    );

    modport slave (
        input  id_valid, id_fire, id_we, id_waddr, id_rd_en, id_raddr, rf_rdata,
        input  fwd_valid, fwd_we, fwd_waddr, fwd_rdy, fwd_wdata,
        input  wb_commit, wb_waddr, flush,
        output opnd, stall, sb_full, stall_cnt
    );

endinterface

// File: rtl/fwd_prio_sel.sv
// Priority match of one source address against the forwarding stages;
// the lowest-index (youngest) matching producer wins.
module fwd_prio_sel
    import id_pkg::*;
#(
    parameter int AW   = AW_DFLT,
    parameter int DW   = DW_DFLT,
    parameter int NFWD = NFWD_DFLT
) (
    input  logic [AW-1:0]      addr,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD*AW-1:0] fwd_waddr,
    input  logic [NFWD-1:0]    fwd_rdy,
    input  logic [NFWD*DW-1:0] fwd_wdata,
    output logic               hit,
    output logic               hit_rdy,
    output logic [DW-1:0]      hit_data
);

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int s = NFWD - 1; s >= 0; s--) begin
            if (fwd_valid[s] && fwd_we[s] && (fwd_waddr[s*AW +: AW] == addr)) begin
                hit      = 1'b1;
                hit_rdy  = fwd_rdy[s];
                hit_data = fwd_wdata[s*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// Decode-stage operand resolution: pending-write scoreboard, forwarding
// selection and load-use stalling, plus a saturating stall-cycle counter.
module id_fwd_scoreboard
    import id_pkg::*;
#(
    parameter int NREG = NREG_DFLT,
    parameter int AW   = AW_DFLT,
    parameter int DW   = DW_DFLT,
    parameter int NRD  = NRD_DFLT,
    parameter int NFWD = NFWD_DFLT,
    parameter int CW   = CW_DFLT
) (
    input  logic              clk,
    input  logic              resetn,
    id_fwd_scoreboard_if.slave bus
);

    localparam logic [CW-1:0] PEND_MAX  = {CW{1'b1}};
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [CW-1:0]      pend_q [NREG];
    logic [CW-1:0]      pend_d [NREG];
    logic [31:0]        stall_cnt_q;
    logic [31:0]        stall_cnt_d;
    logic               inc;
    logic               dec;
    logic [NRD-1:0]     hit;
    logic [NRD-1:0]     hit_rdy;
    logic [NRD*DW-1:0]  hit_data;
    logic [NRD-1:0]     hazard;
    logic [NRD*DW-1:0]  opnd;
    logic               sb_full;
    logic               stall;

    assign inc = bus.id_fire & bus.id_we & (bus.id_waddr != ZERO_ADDR);
    assign dec = bus.wb_commit & (bus.wb_waddr != ZERO_ADDR);

    // A same-register issue and retire cancel; flush discards both.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
        end
        if (bus.flush) begin
            for (int r = 0; r < NREG; r++) begin
                pend_d[r] = '0;
            end
        end else if (!(inc && dec && (bus.id_waddr == bus.wb_waddr))) begin
            if (inc && (pend_q[bus.id_waddr] != PEND_MAX)) begin
                pend_d[bus.id_waddr] = pend_q[bus.id_waddr] + CW'(1);
            end
            if (dec && (pend_q[bus.wb_waddr] != '0)) begin
                pend_d[bus.wb_waddr] = pend_q[bus.wb_waddr] - CW'(1);
            end
        end
        pend_d[0] = '0;
    end

    assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1
                                                                   : stall_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_prio_sel #(
            .AW   (AW),
            .DW   (DW),
            .NFWD (NFWD)
        ) u_sel (
            .addr      (bus.id_raddr[p*AW +: AW]),
            .fwd_valid (bus.fwd_valid),
            .fwd_we    (bus.fwd_we),
            .fwd_waddr (bus.fwd_waddr),
            .fwd_rdy   (bus.fwd_rdy),
            .fwd_wdata (bus.fwd_wdata),
            .hit       (hit[p]),
            .hit_rdy   (hit_rdy[p]),
            .hit_data  (hit_data[p*DW +: DW])
        );
    end

    // Pending writes with no forwarding match live in a slot that cannot forward.
    always_comb begin
        opnd   = '0;
        hazard = '0;
        for (int p = 0; p < NRD; p++) begin
            if (bus.id_raddr[p*AW +: AW] == ZERO_ADDR) begin
                opnd[p*DW +: DW] = '0;
            end else if (!bus.id_rd_en[p]) begin
                opnd[p*DW +: DW] = bus.rf_rdata[p*DW +: DW];
            end else if (hit[p]) begin
                if (hit_rdy[p]) begin
                    opnd[p*DW +: DW] = hit_data[p*DW +: DW];
                end else begin
                    hazard[p] = 1'b1;
                end
            end else if (pend_q[bus.id_raddr[p*AW +: AW]] != '0) begin
                hazard[p] = 1'b1;
            end else begin
                opnd[p*DW +: DW] = bus.rf_rdata[p*DW +: DW];
            end
        end
    end

    assign sb_full = bus.id_valid & bus.id_we & (bus.id_waddr != ZERO_ADDR) &
                     (pend_q[bus.id_waddr] == PEND_MAX);
    assign stall   = bus.id_valid & ((|hazard) | sb_full);

    assign bus.opnd      = opnd;
    assign bus.stall     = stall;
    assign bus.sb_full   = sb_full;
    assign bus.stall_cnt = stall_cnt_q;

    dec_from_empty: assert property (@(posedge clk) disable iff (!resetn)
        (dec && !bus.flush && !(inc && (bus.id_waddr == bus.wb_waddr)))
            |-> (pend_q[bus.wb_waddr] != '0));

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Self-checking bench for id_fwd_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_id_fwd_scoreboard;
    import id_pkg::*;

    localparam int NREG = NREG_DFLT;
    localparam int AW   = AW_DFLT;
    localparam int DW   = DW_DFLT;
    localparam int NRD  = NRD_DFLT;
    localparam int NFWD = NFWD_DFLT;
    localparam int CW   = CW_DFLT;
    localparam int PMAX = (1 << CW) - 1;

    typedef struct packed {
        logic              stall;
        logic              full;
        logic [NRD-1:0]    haz;
        logic [NRD*DW-1:0] opnd;
    } exp_t;

    logic   clk;
    logic   resetn;
    int     m_pend [NREG];
    longint m_cnt;
    int     n_pass;
    int     n_total;
    exp_t   e_lit;

    id_fwd_scoreboard_if bus ();

    id_fwd_scoreboard dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected combinational outputs from the resolution rules and the model's pending counts.
    function automatic exp_t model_eval();
        exp_t e;
        int   a;
        int   win;
        e = '0;
        for (int p = 0; p < NRD; p++) begin
            a = int'(bus.id_raddr[p*AW +: AW]);
            if (a == 0) begin
                e.opnd[p*DW +: DW] = '0;
            end else if (!bus.id_rd_en[p]) begin
                e.opnd[p*DW +: DW] = bus.rf_rdata[p*DW +: DW];
            end else begin
                win = -1;
                for (int s = 0; s < NFWD; s++) begin
                    if (win < 0 && bus.fwd_valid[s] && bus.fwd_we[s] &&
                        int'(bus.fwd_waddr[s*AW +: AW]) == a) begin
                        win = s;
                    end
                end
                if (win >= 0) begin
                    if (bus.fwd_rdy[win]) e.opnd[p*DW +: DW] = bus.fwd_wdata[win*DW +: DW];
                    else                  e.haz[p] = 1'b1;
                end else if (m_pend[a] > 0) begin
                    e.haz[p] = 1'b1;
                end else begin
                    e.opnd[p*DW +: DW] = bus.rf_rdata[p*DW +: DW];
                end
            end
        end
        e.full  = bus.id_valid && bus.id_we && bus.id_waddr != '0 &&
                  m_pend[int'(bus.id_waddr)] == PMAX;
        e.stall = bus.id_valid && ((|e.haz) || e.full);
        return e;
    endfunction

    // Per-cycle comparison against the model, then advance the model to the next edge.
    task automatic compare_cycle();
        exp_t e;
        int   inc_r;
        int   dec_r;
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) m_pend[r] = 0;
            m_cnt = 0;
        end
        e = model_eval();
        check_output("stall", 64'(bus.stall), 64'(e.stall));
        check_output("sb_full", 64'(bus.sb_full), 64'(e.full));
        check_output("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
        for (int p = 0; p < NRD; p++) begin
            if (!e.haz[p]) begin
                check_output($sformatf("opnd%0d", p), 64'(bus.opnd[p*DW +: DW]),
                             64'(e.opnd[p*DW +: DW]));
            end
        end
        if (resetn) begin
            if (bus.flush) begin
                for (int r = 0; r < NREG; r++) m_pend[r] = 0;
            end else begin
                inc_r = (bus.id_fire && bus.id_we && bus.id_waddr != '0) ? int'(bus.id_waddr) : -1;
                dec_r = (bus.wb_commit && bus.wb_waddr != '0) ? int'(bus.wb_waddr) : -1;
                if (inc_r != dec_r) begin
                    if (inc_r >= 0 && m_pend[inc_r] < PMAX) m_pend[inc_r]++;
                    if (dec_r >= 0 && m_pend[dec_r] > 0)    m_pend[dec_r]--;
                end
            end
            if (e.stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid  = 1'b0;
        bus.id_fire   = 1'b0;
        bus.id_we     = 1'b0;
        bus.id_waddr  = '0;
        bus.id_rd_en  = '0;
        bus.id_raddr  = '0;
        bus.rf_rdata  = '0;
        bus.fwd_valid = '0;
        bus.fwd_we    = '0;
        bus.fwd_waddr = '0;
        bus.fwd_rdy   = '0;
        bus.fwd_wdata = '0;
        bus.wb_commit = 1'b0;
        bus.wb_waddr  = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic fire_write(input int r);
        clear_inputs();
        bus.id_valid = 1'b1;
        bus.id_fire  = 1'b1;
        bus.id_we    = 1'b1;
        bus.id_waddr = AW'(r);
        step();
    endtask

    task automatic read_port0(input int r, input logic [DW-1:0] rf);
        clear_inputs();
        bus.id_valid        = 1'b1;
        bus.id_rd_en        = 2'b01;
        bus.id_raddr[0 +: AW] = AW'(r);
        bus.rf_rdata[0 +: DW] = rf;
    endtask

    // Random traffic on r0..r7; retirements only target registers with writes in flight.
    task automatic apply_stimulus();
        exp_t e;
        int   cands[$];
        bus.flush     = ($urandom_range(0, 31) == 0);
        bus.wb_commit = 1'b0;
        bus.wb_waddr  = '0;
        if ($urandom_range(0, 2) == 0) begin
            for (int r = 1; r < 8; r++) if (m_pend[r] > 0) cands.push_back(r);
            bus.wb_commit = 1'b1;
            if (cands.size() > 0 && $urandom_range(0, 3) != 0)
                bus.wb_waddr = AW'(cands[$urandom_range(0, cands.size() - 1)]);
        end
        bus.id_valid = ($urandom_range(0, 3) != 0);
        bus.id_we    = 1'($urandom_range(0, 1));
        bus.id_waddr = AW'($urandom_range(0, 7));
        bus.id_rd_en = NRD'($urandom_range(0, 3));
        for (int p = 0; p < NRD; p++) begin
            bus.id_raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
            bus.rf_rdata[p*DW +: DW] = $urandom;
        end
        bus.fwd_valid = NFWD'($urandom_range(0, 7));
        bus.fwd_we    = NFWD'($urandom_range(0, 7));
        bus.fwd_rdy   = NFWD'($urandom_range(0, 7));
        for (int s = 0; s < NFWD; s++) begin
            bus.fwd_waddr[s*AW +: AW] = AW'($urandom_range(0, 7));
            bus.fwd_wdata[s*DW +: DW] = $urandom;
        end
        e = model_eval();
        bus.id_fire = bus.id_valid && !e.stall && ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_cnt   = 0;
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
        resetn = 1'b0;
        clear_inputs();
        step();
        step();
        resetn = 1'b1;

        // Plain register-file read, and r0 reads as zero.
        read_port0(5, 32'h11);
        bus.id_rd_en          = 2'b11;
        bus.rf_rdata[DW +: DW] = 32'h22;
        #2;
        check_output("plain_opnd", 64'(bus.opnd[0 +: DW]), 64'h11);
        check_output("r0_opnd", 64'(bus.opnd[DW +: DW]), 64'h0);
        check_output("plain_stall", 64'(bus.stall), 64'h0);
        check_output("reset_stall_cnt", 64'(bus.stall_cnt), 64'h0);
        step();

        // Youngest producer wins over WB.
        read_port0(7, 32'h77);
        bus.fwd_valid = 3'b101;
        bus.fwd_we    = 3'b101;
        bus.fwd_rdy   = 3'b101;
        bus.fwd_waddr[0*AW +: AW] = AW'(7);
        bus.fwd_waddr[2*AW +: AW] = AW'(7);
        bus.fwd_wdata[0*DW +: DW] = 32'hAAAA;
        bus.fwd_wdata[2*DW +: DW] = 32'hBBBB;
        #2;
        e_lit = model_eval();
        check_output("model_youngest", 64'(e_lit.opnd[0 +: DW]), 64'hAAAA);
        check_output("youngest_opnd", 64'(bus.opnd[0 +: DW]), 64'hAAAA);
        check_output("youngest_stall", 64'(bus.stall), 64'h0);
        step();

        // Load-use: EX not ready, then MEM forwards.
        read_port0(3, 32'h33);
        bus.fwd_valid = 3'b001;
        bus.fwd_we    = 3'b001;
        bus.fwd_waddr[0 +: AW] = AW'(3);
        #2;
        e_lit = model_eval();
        check_output("model_load_use", 64'(e_lit.stall), 64'h1);
        check_output("load_use_stall", 64'(bus.stall), 64'h1);
        step();
        read_port0(3, 32'h33);
        bus.fwd_valid = 3'b010;
        bus.fwd_we    = 3'b010;
        bus.fwd_rdy   = 3'b010;
        bus.fwd_waddr[1*AW +: AW] = AW'(3);
        bus.fwd_wdata[1*DW +: DW] = 32'h1234;
        #2;
        check_output("mem_fwd_opnd", 64'(bus.opnd[0 +: DW]), 64'h1234);
        check_output("mem_fwd_stall", 64'(bus.stall), 64'h0);
        check_output("load_use_cnt", 64'(bus.stall_cnt), 64'h1);
        step();

        // Writes to r0 never count; r9 saturates after three in flight.
        fire_write(0);
        fire_write(9);
        fire_write(9);
        fire_write(9);
        clear_inputs();
        bus.id_valid = 1'b1;
        bus.id_we    = 1'b1;
        bus.id_waddr = AW'(9);
        #2;
        check_output("r9_full", 64'(bus.sb_full), 64'h1);
        check_output("r9_full_stall", 64'(bus.stall), 64'h1);
        step();
        bus.id_fire   = 1'b1;
        bus.wb_commit = 1'b1;
        bus.wb_waddr  = AW'(9);
        step();
        clear_inputs();
        bus.id_valid = 1'b1;
        bus.id_we    = 1'b1;
        bus.id_waddr = AW'(9);
        #2;
        check_output("r9_inc_dec_full", 64'(bus.sb_full), 64'h1);
        step();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            bus.wb_commit = 1'b1;
            bus.wb_waddr  = AW'(9);
            step();
        end

        // Pending write with no forwarding producer.
        fire_write(4);
        read_port0(4, 32'h44);
        bus.wb_commit = 1'b1;
        bus.wb_waddr  = AW'(4);
        #2;
        check_output("unfwd_stall", 64'(bus.stall), 64'h1);
        step();
        read_port0(4, 32'h44);
        #2;
        check_output("unfwd_release", 64'(bus.stall), 64'h0);
        check_output("unfwd_opnd", 64'(bus.opnd[0 +: DW]), 64'h44);
        step();

        // Flush beats a same-cycle issue.
        fire_write(2);
        fire_write(2);
        read_port0(2, 32'h55);
        #2;
        check_output("flush_pre_stall", 64'(bus.stall), 64'h1);
        step();
        clear_inputs();
        bus.flush    = 1'b1;
        bus.id_valid = 1'b1;
        bus.id_fire  = 1'b1;
        bus.id_we    = 1'b1;
        bus.id_waddr = AW'(2);
        step();
        read_port0(2, 32'h55);
        #2;
        check_output("flush_stall", 64'(bus.stall), 64'h0);
        check_output("flush_opnd", 64'(bus.opnd[0 +: DW]), 64'h55);
        step();

        // Asynchronous reset between edges clears a pending stall at once.
        fire_write(4);
        read_port0(4, 32'h66);
        #2;
        check_output("pre_reset_stall", 64'(bus.stall), 64'h1);
        resetn = 1'b0;
        #1;
        check_output("async_reset_stall", 64'(bus.stall), 64'h0);
        step();
        step();
        resetn = 1'b1;
        #2;
        check_output("post_reset_stall", 64'(bus.stall), 64'h0);
        check_output("post_reset_cnt", 64'(bus.stall_cnt), 64'h0);
        step();

        repeat (3000) begin
            apply_stimulus();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_fwd_scoreboard.md
Name: id_fwd_scoreboard

Overview:
- Parametrised operand-resolution unit for the decode (ID) stage.
- Tracks in-flight register writes in a per-register pending-count scoreboard.
- Selects each source operand from the youngest matching forwarding stage, or from the register file, and stalls only when the producer's data is not yet available (e.g. load in EX).
- Replaces "stall on any RAW hazard" with forwarding plus load-use stalling, generalised to NRD read ports and NFWD forwarding stages.

Parameters:
- NREG, 32: architectural GPR count; register 0 is hard-wired zero.
- AW, 5: register address width, equal to clog2(NREG).
- DW, 32: data width.
- NRD, 2: number of source read ports.
- NFWD, 3: number of forwarding stages; index 0 is the youngest (EX), NFWD-1 the oldest (WB).
- CW, 2: pending-counter width; the maximum number of outstanding writes per register is 2^CW-1.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_fire  in  1  the ID instruction advances this cycle; only legal when id_valid & ~stall.
- id_we  in  1  the ID instruction writes a GPR.
- id_waddr  in  AW  destination register.
- id_rd_en  in  NRD  per-port source-used flag.
- id_raddr  in  NRD*AW  source addresses; these also drive the register file.
- rf_rdata  in  NRD*DW  register-file read data.
- fwd_valid  in  NFWD  stage holds a valid instruction.
- fwd_we  in  NFWD  stage instruction writes a GPR.
- fwd_waddr  in  NFWD*AW  stage destination.
- fwd_rdy  in  NFWD  stage result is available this cycle.
- fwd_wdata  in  NFWD*DW  stage result.
- wb_commit  in  1  a GPR write retires this cycle.
- wb_waddr  in  AW  retired destination.
- flush  in  1  the pipeline is emptied; clears the scoreboard.
- opnd  out  NRD*DW  resolved operands.
- stall  out  1  ID must hold.
- sb_full  out  1  the ID destination counter is saturated.
- stall_cnt  out  32  saturating count of stall cycles.

Behaviour:
- **Reset (async, resetn=0):**
  - All pending counters go to 0 and stall_cnt goes to 0.
  - Combinational outputs then evaluate to: stall=0 (no pending); opnd = rf_rdata, or 0 for address 0; sb_full=0.
- **Scoreboard:** one CW-bit counter pend[r] for r = 1..NREG-1; pend[0] is constantly 0.
  - inc = id_fire & id_we & (id_waddr != 0).
  - dec = wb_commit & (wb_waddr != 0).
  - When inc and dec hit the same register in the same cycle, the counter is unchanged.
  - Decrementing a zero counter is illegal. RTL asserts it in simulation and holds the counter at 0.
  - flush has priority over inc and dec: all counters go to 0 on the next edge. A same-cycle inc is discarded.
- **Operand resolution** (combinational, per port p, with a = raddr[p]):
  - If a == 0 or ~id_rd_en[p]: opnd = 0 (when a == 0) or rf_rdata (when ~id_rd_en[p]); no hazard.
  - Otherwise the match set is stages s with fwd_valid[s] & fwd_we[s] & (fwd_waddr[s] == a). The winner is the lowest-index match (youngest producer).
  - Winner with fwd_rdy[s]=1: opnd = fwd_wdata[s].
  - Winner with fwd_rdy[s]=0: hazard; opnd is don't-care.
  - No match but pend[a] != 0: the producer is in an unforwarded slot, so hazard.
  - No match and pend[a] == 0: opnd = rf_rdata[p].
- **Stall and saturation:**
  - sb_full = id_valid & id_we & (id_waddr != 0) & (pend[id_waddr] == max).
  - stall = id_valid & (any port hazard | sb_full).
- **stall_cnt:** increments on every cycle with stall=1 and saturates at 0xFFFFFFFF. flush does not clear it.
- **Timing:**
  - Latency: zero cycles for opnd and stall.
  - Scoreboard state updates one cycle after id_fire or wb_commit.
  - A WB stage that forwards (index NFWD-1) resolves a hazard in the same cycle it commits.
- **Reset mid-operation:** the asynchronous clear takes effect immediately. The state after release is identical to the power-on state.

Decomposition:
- Shared package id_pkg: parameter defaults NREG/AW/DW and constant REG_ZERO=0.
- One natural sub-module, fwd_prio_sel: per-port priority match and mux over NFWD stages, instantiated NRD times.
- The scoreboard counters and stall counter stay in the top module.

Test Plan:
- **Reset and plain read:** resetn low, then high. Read r5 with rf_rdata=0x11 and no pending -> stall=0, opnd=0x11, stall_cnt=0.
- **Youngest wins:** r7 matched in EX (0xAAAA, rdy=1) and WB (0xBBBB, rdy=1) -> opnd=0xAAAA, stall=0.
- **Load-use:** EX holds a load to r3 with fwd_rdy=0 and ID reads r3 -> stall=1 for one cycle, stall_cnt=1. Next cycle, MEM matches r3 with rdy=1 and 0x1234 -> opnd=0x1234, stall=0.
- **Scoreboard and r0:**
  - id_fire writing r0 -> pend unchanged.
  - Three fires writing r9 (CW=2) -> sb_full=1 on the fourth, stall=1.
  - Same-cycle inc and dec on r9 -> count stays 3.
- **Unforwarded pending:** pend[r4]=1 with no fwd match -> stall=1. wb_commit r4 -> pend[r4]=0 and stall drops the next cycle.
- **Flush and async reset:**
  - flush with pend[r2]=2 plus a same-cycle id_fire writing r2 -> pend[r2]=0.
  - resetn dropped mid-stall, between clock edges -> stall=0 before the next clk edge.
